amplitude_error_detector: RTL and testbench

AMPLITUDE_ERROR_DETECTOR -- requirements
Module: amplitude_error_detector

---
 rtl/amplitude_error_detector_pkg.sv | 19 +
 rtl/amplitude_error_detector_if.sv | 20 ++
 rtl/amplitude_error_detector_abs_sat16.sv | 17 +
 rtl/global_params.svh | 6 +
 rtl/amplitude_error_detector.sv | 133 +++++++++++++
 tb/tb_amplitude_error_detector.sv | 186 ++++++++++++++++++
 6 files changed

// File: rtl/amplitude_error_detector_pkg.sv
// Shared types, widths and the amplitude-error helper for amplitude_error_detector.
`include "global_params.svh"

package amplitude_error_detector_pkg;

    localparam int EPS_W = `EPS_WORD_W;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Reference minus mean as a 17-bit signed value; both operands are unsigned.
    function automatic logic signed [16:0] amp_err(input logic [15:0] ref_level,
                                                   input logic [14:0] mean);
        return $signed({1'b0, ref_level}) - $signed({2'b00, mean});
    endfunction

endpackage

// File: rtl/amplitude_error_detector_if.sv
// Sample/reference input bundle and eps output bundle of amplitude_error_detector.
interface amplitude_error_detector_if;
    import amplitude_error_detector_pkg::*;

    logic signed [15:0]      sample_i;
    logic                    valid_i;
    logic [15:0]             ref_level_i;
    logic signed [EPS_W-1:0] eps_o;
    logic                    valid_o;

    modport master (
        output sample_i, valid_i, ref_level_i,
        input  eps_o, valid_o
    );

    modport slave (
        input  sample_i, valid_i, ref_level_i,
        output eps_o, valid_o
    );
endinterface

// File: rtl/amplitude_error_detector_abs_sat16.sv
// Combinational absolute value of a 16-bit signed sample; -32768 saturates to 32767.
module abs_sat16 (
    input  logic signed [15:0] x,
    output logic [14:0]        mag
);
    logic [15:0] neg;

    assign neg = 16'(-x);

    always_comb begin
        mag = x[14:0];
        if (x == 16'sh8000)
            mag = 15'h7FFF;
        else if (x[15])
            mag = neg[14:0];
    end
endmodule

// File: rtl/global_params.svh
// Project-wide parameters shared by all blocks: reset polarity and eps word width.
`ifndef GLOBAL_PARAMS_SVH
`define GLOBAL_PARAMS_SVH
`define RST_VAL 1'b1
`define EPS_WORD_W 32
`endif

// File: rtl/amplitude_error_detector.sv
// Block-mean amplitude error detector: averages |x| over 2^LOG2_BLOCK samples, emits eps.
// Optional deadband on the error is enabled by defining AMP_ERR_DEADBAND_EN.
`include "global_params.svh"

module amplitude_error_detector
    import amplitude_error_detector_pkg::*;
#(
    parameter int LOG2_BLOCK = 6,
    parameter int EPS_SHIFT  = 8,
    parameter int DEADBAND   = 16
) (
    input logic                    clk,
    input logic                    rst,
    amplitude_error_detector_if.slave bus
);
    localparam int SUM_W = 15 + LOG2_BLOCK;

    if (LOG2_BLOCK < 1 || LOG2_BLOCK > 10) begin : g_bad_log2
        $error("LOG2_BLOCK must be within 1..10");
    end
    if (EPS_SHIFT < 0 || EPS_SHIFT > 15) begin : g_bad_shift
        $error("EPS_SHIFT must be within 0..15");
    end
    if (DEADBAND < 0) begin : g_bad_deadband
        $error("DEADBAND must be non-negative");
    end

    logic signed [15:0]      sample_s1;
    logic                    valid_s1;
    logic [15:0]             ref_s1;
    logic [14:0]             mag;
    logic [LOG2_BLOCK-1:0]   count;
    logic [SUM_W-1:0]        sum;
    logic [SUM_W-1:0]        sum_next;
    logic [SUM_W-1:0]        hold;
    logic [15:0]             ref_blk;
    logic [15:0]             ref_hold;
    logic                    done;
    logic                    terminal;
    logic [14:0]             mean;
    logic signed [16:0]      err;
    logic signed [EPS_W-1:0] eps_ext;
    logic signed [EPS_W-1:0] eps_calc;
    logic signed [EPS_W-1:0] eps_next;
    state_t                  state;
    state_t                  next_state;

    always_ff @(posedge clk) begin
        if (rst == `RST_VAL) begin
            sample_s1 <= '0;
            valid_s1  <= 1'b0;
            ref_s1    <= '0;
        end else begin
            sample_s1 <= bus.sample_i;
            valid_s1  <= bus.valid_i;
            ref_s1    <= bus.ref_level_i;
        end
    end

    abs_sat16 u_abs (
        .x   (sample_s1),
        .mag (mag)
    );

    always_ff @(posedge clk) begin
        if (rst == `RST_VAL)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (state == IDLE && valid_s1)
            next_state = RUN;
    end

    assign sum_next = sum + SUM_W'(mag);
    assign terminal = valid_s1 && (count == '1);

    // The terminal sample goes straight into hold, so the next cycle starts a fresh block.
    always_ff @(posedge clk) begin
        if (rst == `RST_VAL) begin
            count    <= '0;
            sum      <= '0;
            hold     <= '0;
            ref_blk  <= '0;
            ref_hold <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (valid_s1) begin
                if (count == '0)
                    ref_blk <= ref_s1;
                if (terminal) begin
                    hold     <= sum_next;
                    ref_hold <= ref_blk;
                    sum      <= '0;
                    count    <= '0;
                    done     <= 1'b1;
                end else begin
                    sum   <= sum_next;
                    count <= count + LOG2_BLOCK'(1);
                end
            end
        end
    end

    assign mean     = 15'(hold >> LOG2_BLOCK);
    assign err      = amp_err(ref_hold, mean);
    assign eps_ext  = EPS_W'(err);
    assign eps_calc = eps_ext <<< EPS_SHIFT;

`ifdef AMP_ERR_DEADBAND_EN
    logic [16:0] err_mag;

    assign err_mag  = err[16] ? 17'(-err) : 17'(err);
    assign eps_next = (err_mag <= 17'(DEADBAND)) ? '0 : eps_calc;
`else
    assign eps_next = eps_calc;
`endif

    always_ff @(posedge clk) begin
        if (rst == `RST_VAL) begin
            bus.eps_o   <= '0;
            bus.valid_o <= 1'b0;
        end else begin
            bus.valid_o <= done;
            if (done)
                bus.eps_o <= eps_next;
        end
    end
endmodule

// File: tb/tb_amplitude_error_detector.sv
// Scoreboard bench for amplitude_error_detector; honours AMP_ERR_DEADBAND_EN like the DUT.
`timescale 1ns/1ps

module tb_amplitude_error_detector;
    import amplitude_error_detector_pkg::*;

    localparam int LOG2_BLOCK = 6;
    localparam int EPS_SHIFT  = 8;
    localparam int DEADBAND   = 16;
    localparam int N          = 1 << LOG2_BLOCK;

    typedef struct {
        int eps;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t exp_q[$];
    exp_t mon_e;
    int   tests    = 0;
    int   failed   = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;
    int   last_eps = 0;
    int   m_count  = 0;
    int   m_sum    = 0;
    int   m_ref    = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    amplitude_error_detector_if bus ();

    amplitude_error_detector #(
        .LOG2_BLOCK (LOG2_BLOCK),
        .EPS_SHIFT  (EPS_SHIFT),
        .DEADBAND   (DEADBAND)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag,
                   $signed(observed), $signed(expected));
        end
    endtask

    task automatic modelReset();
        m_count  = 0;
        m_sum    = 0;
        m_ref    = 0;
        last_eps = 0;
        exp_q.delete();
    endtask

    // Drives one cycle of input and advances the reference model.
    task automatic applyStimulus(input logic signed [15:0] s, input logic v,
                                 input logic [15:0] r);
        int   a;
        int   mean;
        int   err;
        int   eps;
        exp_t e;
        @(posedge clk);
        #1;
        bus.sample_i    = s;
        bus.valid_i     = v;
        bus.ref_level_i = r;
        if (v) begin
            if (s == -16'sd32768)
                a = 32767;
            else if (s < 0)
                a = -int'(s);
            else
                a = int'(s);
            if (m_count == 0)
                m_ref = int'(r);
            m_sum   = m_sum + a;
            m_count = m_count + 1;
            if (m_count == N) begin
                mean = m_sum / N;
                err  = m_ref - mean;
                eps  = err * (1 << EPS_SHIFT);
`ifdef AMP_ERR_DEADBAND_EN
                if (err <= DEADBAND && err >= -DEADBAND)
                    eps = 0;
`endif
                e.eps = eps;
                e.due = cyc + 3;
                exp_q.push_back(e);
                m_count = 0;
                m_sum   = 0;
            end
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(16'($urandom), 1'b0, 16'($urandom));
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst         = 1'b1;
        mon_en      = 1'b0;
        bus.valid_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid_o", 32'(bus.valid_o), 32'd0);
        checkOutput("rst_eps_o", bus.eps_o, 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    // Every cycle: either the scheduled pulse with its eps, or no pulse and eps held.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                mon_e = exp_q.pop_front();
                checkOutput("valid_o_pulse", 32'(bus.valid_o), 32'd1);
                checkOutput("eps_o", bus.eps_o, mon_e.eps);
                last_eps = mon_e.eps;
            end else begin
                checkOutput("valid_o_idle", 32'(bus.valid_o), 32'd0);
                checkOutput("eps_o_hold", bus.eps_o, last_eps);
            end
        end
    end

    initial begin
        bus.sample_i    = '0;
        bus.valid_i     = 1'b0;
        bus.ref_level_i = '0;
        doReset();

        for (int i = 0; i < N; i++)
            applyStimulus(16'sd4096, 1'b1, 16'd8192);

        for (int i = 0; i < N; i++)
            applyStimulus((i % 2 == 0) ? 16'sd16384 : -16'sd16384, 1'b1, 16'd8192);
        idleCycles(5);

        for (int i = 0; i < N; i++)
            applyStimulus(-16'sd32768, 1'b1, 16'd0);
        idleCycles(5);

        for (int i = 0; i < 2 * N; i++) begin
            idleCycles($urandom_range(0, 3));
            applyStimulus(16'sd4096, 1'b1, 16'd8192);
        end
        idleCycles(5);

        applyStimulus(16'sd1000, 1'b1, 16'd5000);
        for (int i = 1; i < N; i++)
            applyStimulus(-16'sd1000, 1'b1, 16'($urandom));
        idleCycles(5);

        for (int i = 0; i < 40; i++)
            applyStimulus(16'sd4096, 1'b1, 16'd8192);
        doReset();
        for (int i = 0; i < N; i++)
            applyStimulus(16'sd4096, 1'b1, 16'd8192);
        idleCycles(5);

        for (int i = 0; i < N; i++)
            applyStimulus(16'sd8190, 1'b1, 16'd8192);
        idleCycles(10);

        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
